mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter AddrSize, default 32, address width in bits.
REQ-002 Parameter DataSize, default 64, data width in bits; strobe width is DataSize/8.
REQ-003 Parameter NumWords, default 1024, storage depth in DataSize-bit words.
REQ-004 Parameter RspLatency, default 2, legal range 1..4, cycles from grant to response.
REQ-005 Parameter MaxOutstanding, default 2, legal range 1..4, maximum granted-but-unanswered requests.
REQ-006 clk_i  input  1  single clock; all state on rising edge.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 mem_req_i  input  1  request valid from the initiator.
REQ-009 mem_gnt_o  output  1  request accepted this cycle.
REQ-010 mem_addr_i  input  AddrSize  byte address, expected DataSize/8-aligned.
REQ-011 mem_wdata_i  input  DataSize  write data.
REQ-012 mem_strb_i  input  DataSize/8  byte write enables.
REQ-013 mem_we_i  input  1  1 = write, 0 = read.
REQ-014 mem_rvalid_o  output  1  response valid, one pulse per granted request.
REQ-015 mem_rdata_o  output  DataSize  read data, valid with mem_rvalid_o.
REQ-016 err_o  output  1  sticky error flag.

Function
REQ-017 mem_gnt_o = mem_req_i AND (outstanding count < MaxOutstanding), combinational; no ready input on the response side.
REQ-018 Handshake: a request transfers only in a cycle with mem_req_i = mem_gnt_o = 1; addr/wdata/strb/we are sampled in that cycle only.
REQ-019 Word index = mem_addr_i[AddrSize-1 : log2(DataSize/8)]; the low log2(DataSize/8) bits are the misalignment offset.
REQ-020 Granted write with valid index: each byte b with strb[b] = 1 is written in the grant cycle; bytes with strb[b] = 0 keep their old values.
REQ-021 Granted read with valid index: the word is read in the grant cycle, so a read granted one cycle after a write to the same word returns the new data.
REQ-022 Every granted request produces exactly one mem_rvalid_o pulse, exactly RspLatency cycles after the grant; responses are returned in grant order.
REQ-023 mem_rdata_o = stored word for reads, '0 for writes, and '0 whenever mem_rvalid_o = 0.
REQ-024 An index >= NumWords or a nonzero offset is an error access: the write is dropped, read data is '0, a response is still issued, and err_o is set.
REQ-025 err_o remains 1 until reset.
REQ-026 The outstanding counter increments on grant and decrements on mem_rvalid_o; when both occur in the same cycle it holds its value; it never exceeds MaxOutstanding or falls below 0.
REQ-027 Back-to-back grants in consecutive cycles are allowed while the counter is below its limit; with RspLatency=2 and MaxOutstanding=2, sustained throughput is one request per cycle.

Reset
REQ-028 While rst_ni = 0: mem_gnt_o = 0, mem_rvalid_o = 0, mem_rdata_o = '0, err_o = 0, outstanding = 0, and the response pipeline is cleared.
REQ-029 Reset asserted mid-operation discards all in-flight responses; no rvalid pulse appears after deassertion for requests granted before reset.
REQ-030 Storage contents are not reset; a read of an unwritten word returns an undefined value.

Structure
REQ-031 Shared package mem_pkg holds the addr_t, data_t and strb_t typedefs and the address-to-word-index conversion function.
REQ-032 Sub-module mem_rsp_pipe is a RspLatency-deep valid/data shift register with asynchronous reset; storage and grant logic stay in mem_responder.

Verification
REQ-033 Write addr 0x10, wdata 0x1122334455667788, strb 0xFF; then read 0x10 -> gnt each cycle, rvalid 2 cycles after each grant, read rdata 0x1122334455667788.
REQ-034 Preload 0x10 with 0x1122334455667788; write wdata all-0xAA with strb 0x0F; read 0x10 -> rdata 0x11223344AAAAAAAA.
REQ-035 MaxOutstanding=1, RspLatency=3, req held high -> one grant every 3 cycles, counter never exceeds 1.
REQ-036 Read addr 0x13, then read index NumWords -> both responses have rdata 0 and rvalid, err_o rises after the first and stays 1.
REQ-037 Two reads granted, then rst_ni pulsed low for 1 cycle before responses -> no rvalid after reset, gnt 0 during reset, err_o 0.
REQ-038 Random req/we/strb traffic for 10k cycles against a reference model -> every grant yields one in-order rvalid at exactly +RspLatency with matching data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and address helpers for the memory responder slice.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;

    function automatic addr_t word_index(input addr_t addr, input int unsigned offs_w);
        return addr >> offs_w;
    endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency response shift register: valid/data delayed by Depth cycles.
module mem_rsp_pipe #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_in,
    input  logic [Width-1:0] data_in,
    output logic             pre_valid,
    output logic             valid_out,
    output logic [Width-1:0] data_out
);

    logic [Depth-1:0] vld;
    logic [Width-1:0] dat [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld <= '0;
            for (int i = 0; i < Depth; i++) dat[i] <= '0;
        end else begin
            vld[0] <= valid_in;
            dat[0] <= data_in;
            for (int i = 1; i < Depth; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign valid_out = vld[Depth-1];
    assign data_out  = dat[Depth-1];

    // pre_valid: an entry will be presented on valid_out after the next edge
    generate
        if (Depth == 1) begin : g_short
            assign pre_valid = valid_in;
        end else begin : g_long
            assign pre_valid = vld[Depth-2];
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Single-port memory slave with req/gnt handshake and fixed-latency in-order responses.
import mem_pkg::*;

module mem_responder #(
    parameter int unsigned AddrSize       = 32,
    parameter int unsigned DataSize       = 64,
    parameter int unsigned NumWords       = 1024,
    parameter int unsigned RspLatency     = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mem_req_i,
    output logic                  mem_gnt_o,
    input  logic [AddrSize-1:0]   mem_addr_i,
    input  logic [DataSize-1:0]   mem_wdata_i,
    input  logic [DataSize/8-1:0] mem_strb_i,
    input  logic                  mem_we_i,
    output logic                  mem_rvalid_o,
    output logic [DataSize-1:0]   mem_rdata_o,
    output logic                  err_o
);

    localparam int unsigned BYTES  = DataSize / 8;
    localparam int unsigned OFFS_W = $clog2(BYTES);
    localparam int unsigned MEM_AW = $clog2(NumWords);
    localparam logic [2:0]  MAX_OUT = 3'(MaxOutstanding);

    logic [2:0]          outstanding;
    addr_t               idx_full;
    logic [MEM_AW-1:0]   widx;
    logic                access_ok;
    logic [DataSize-1:0] rsp_data;
    logic                rsp_valid;
    logic                rsp_pre_valid;
    logic [DataSize-1:0] rsp_data_q;
    logic [DataSize-1:0] mem [NumWords];

    assign mem_gnt_o = mem_req_i & rst_ni & (outstanding < MAX_OUT);

    assign idx_full  = word_index(addr_t'(mem_addr_i), OFFS_W);
    assign access_ok = (idx_full < addr_t'(NumWords)) && (mem_addr_i[OFFS_W-1:0] == '0);
    assign widx      = idx_full[MEM_AW-1:0];

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_gnt_o && mem_we_i && access_ok) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mem_strb_i[b]) mem[widx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
            end
        end
    end

    assign rsp_data = (mem_gnt_o && !mem_we_i && access_ok) ? mem[widx] : '0;

    mem_rsp_pipe #(
        .Depth (RspLatency),
        .Width (DataSize)
    ) u_rsp_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_in  (mem_gnt_o),
        .data_in   (rsp_data),
        .pre_valid (rsp_pre_valid),
        .valid_out (rsp_valid),
        .data_out  (rsp_data_q)
    );

    assign mem_rvalid_o = rsp_valid;
    assign mem_rdata_o  = rsp_valid ? rsp_data_q : '0;

    // The count drops on the same edge that raises rvalid, so a request stops
    // counting as outstanding in the cycle its response is presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
            err_o       <= 1'b0;
        end else begin
            if (mem_gnt_o && !rsp_pre_valid)      outstanding <= outstanding + 3'd1;
            else if (!mem_gnt_o && rsp_pre_valid) outstanding <= outstanding - 3'd1;
            if (mem_gnt_o && !access_ok) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: directed cases plus random traffic against a queue-based reference model.
module tb_mem_responder;
    import mem_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    always #5 clk = ~clk;

    logic  req, we, gnt, rvalid, err;
    addr_t addr;
    data_t wdata, rdata;
    strb_t strb;

    logic  req2, we2, gnt2, rvalid2, err2;
    addr_t addr2;
    data_t wdata2, rdata2;
    strb_t strb2;

    mem_responder dut (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_gnt_o(gnt),
        .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_strb_i(strb), .mem_we_i(we),
        .mem_rvalid_o(rvalid), .mem_rdata_o(rdata), .err_o(err)
    );

    mem_responder #(.RspLatency(3), .MaxOutstanding(1)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req2), .mem_gnt_o(gnt2),
        .mem_addr_i(addr2), .mem_wdata_i(wdata2), .mem_strb_i(strb2), .mem_we_i(we2),
        .mem_rvalid_o(rvalid2), .mem_rdata_o(rdata2), .err_o(err2)
    );

    typedef struct {
        int    due;
        data_t data;
    } rsp_t;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    rsp_t  rq[$];
    data_t mem_m [1024];
    logic  err_m = 1'b0;

    task automatic chk(input string tag, input data_t obs, input data_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of the default-parameter DUT: check this cycle's response, then drive and check the grant.
    task automatic step(input logic r, input logic w, input addr_t a, input data_t d, input strb_t s);
        logic        exp_gnt, ok;
        int unsigned idx;
        data_t       exp_data;
        @(negedge clk);
        cyc++;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rvalid", data_t'(rvalid), 64'd1);
            chk("rdata", rdata, rq[0].data);
            void'(rq.pop_front());
        end else begin
            chk("rvalid_idle", data_t'(rvalid), 64'd0);
            chk("rdata_idle", rdata, 64'd0);
        end
        chk("err", data_t'(err), data_t'(err_m));
        req = r; we = w; addr = a; wdata = d; strb = s;
        #1;
        exp_gnt = r && (rq.size() < 2);
        chk("gnt", data_t'(gnt), data_t'(exp_gnt));
        if (exp_gnt) begin
            idx = a / 8;
            ok  = (idx < 1024) && (a % 8 == 0);
            if (!ok) err_m = 1'b1;
            exp_data = '0;
            if (w) begin
                if (ok)
                    for (int b = 0; b < 8; b++)
                        if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
            end else if (ok) begin
                exp_data = mem_m[idx];
            end
            rq.push_back('{cyc + 2, exp_data});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        addr_t ra;
        int    sel;
        req = 1'b1; we = 1'b0; addr = '0; wdata = '0; strb = '0;
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0; strb2 = '0;

        #12;
        chk("rst_gnt", data_t'(gnt), 64'd0);
        chk("rst_rvalid", data_t'(rvalid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_err", data_t'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 1'b0;

        // full write then read back
        step(1'b1, 1'b1, 32'h10, 64'h1122334455667788, 8'hFF);
        step(1'b1, 1'b0, 32'h10, '0, '0);
        idle(3);

        // partial strobe
        step(1'b1, 1'b1, 32'h10, {8{8'hAA}}, 8'h0F);
        step(1'b1, 1'b0, 32'h10, '0, '0);
        idle(3);
        chk("partial_word", mem_m[2], 64'h11223344AAAAAAAA);

        // misaligned and out-of-range reads
        step(1'b1, 1'b0, 32'h13, '0, '0);
        step(1'b1, 1'b0, 32'h2000, '0, '0);
        idle(4);

        // reset while two reads are in flight
        step(1'b1, 1'b0, 32'h10, '0, '0);
        step(1'b1, 1'b0, 32'h10, '0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", data_t'(gnt), 64'd0);
        chk("midrst_rvalid", data_t'(rvalid), 64'd0);
        chk("midrst_err", data_t'(err), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_gnt2", data_t'(gnt), 64'd0);
        chk("midrst_rvalid2", data_t'(rvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 1'b0;
        cyc += 2;
        rq.delete();
        err_m = 1'b0;
        idle(4);

        // MaxOutstanding=1, RspLatency=3 instance with req held high
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            cyc++;
            if (k == 0) begin
                req2 = 1'b1; we2 = 1'b1; addr2 = 32'h0; wdata2 = 64'h5A5A; strb2 = 8'hFF;
            end
            #1;
            chk("lim_gnt", data_t'(gnt2), data_t'(k % 3 == 0));
            chk("lim_rvalid", data_t'(rvalid2), data_t'(k >= 3 && k % 3 == 0));
            chk("lim_rdata", rdata2, 64'd0);
            chk("lim_outstanding", data_t'(dut2.outstanding <= 3'd1), 64'd1);
        end
        req2 = 1'b0;

        // preload the random window so no read sees an unwritten word
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b1, addr_t'(i * 8), {$urandom, $urandom}, 8'hFF);
        idle(3);

        for (int i = 0; i < 10000; i++) begin
            sel = int'($urandom_range(0, 31));
            if (sel == 0)      ra = 32'h2000 + 8 * $urandom_range(0, 15);
            else if (sel == 1) ra = 8 * $urandom_range(0, 15) + $urandom_range(1, 7);
            else               ra = 8 * $urandom_range(0, 15);
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra,
                 {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        end
        idle(4);
        chk("drained", data_t'(rq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
